uart_tx_framer: RTL and testbench

- Serial transmit framer sitting directly downstream of Parity_check.
- On a send request it latches the data byte, parity mode and the parity bit from Parity_check. It then shifts out one UART frame on `tx`, least-significant bit first: start bit, 8 data bits, optional parity bit, stop bit(s).
- It computes no parity itself; it consumes Parity_check's `parity_bit` output.

---
 rtl/uart_tx_framer_if.sv | 20 ++
 rtl/uart_tx_framer.sv | 123 ++++++++++++
 tb/tb_uart_tx_framer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - send request, parity input and serial line bundle for uart_tx_framer
interface uart_tx_framer_if;
    logic       send;
    logic [7:0] data_in;
    logic [1:0] parity_type;
    logic       parity_bit;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output send, data_in, parity_type, parity_bit,
        input  tx, busy, done
    );

    modport slave (
        input  send, data_in, parity_type, parity_bit,
        output tx, busy, done
    );
endinterface

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART frame serializer consuming an external parity bit
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_framer_if.slave   bus
);
    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] BAUD_LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] BAUD_ONE  = W'(1);
    localparam logic [2:0]   STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t       state, state_d;
    logic [W-1:0] baud_cnt, baud_d;
    logic [2:0]   bit_idx, bit_idx_d;
    logic [7:0]   shift_reg, shift_d;
    logic         par_en, par_en_d;
    logic         par_val, par_val_d;
    logic         tx_q, tx_d;
    logic         busy_q, done_q, done_d;
    logic         last_tick;

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    assign last_tick = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_d   = state;
        baud_d    = baud_cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift_reg;
        par_en_d  = par_en;
        par_val_d = par_val;
        done_d    = 1'b0;

        // Baud counter advances in every non-idle state and wraps on each bit boundary.
        if (state != IDLE)
            baud_d = last_tick ? '0 : baud_cnt + BAUD_ONE;

        case (state)
            IDLE: begin
                if (bus.send) begin
                    shift_d   = bus.data_in;
                    par_en_d  = (bus.parity_type == 2'b01) || (bus.parity_type == 2'b10);
                    par_val_d = bus.parity_bit;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (last_tick)
                    state_d = DATA;
            end
            DATA: begin
                if (last_tick) begin
                    shift_d = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = par_en ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (last_tick)
                    state_d = STOP;
            end
            STOP: begin
                // bit_idx is reused to count stop-bit periods.
                if (last_tick) begin
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_d = '0;
                        state_d   = IDLE;
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is derived from the next state so tx is a pure register output.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_val_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_en    <= 1'b0;
            par_val   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            baud_cnt  <= baud_d;
            bit_idx   <= bit_idx_d;
            shift_reg <= shift_d;
            par_en    <= par_en_d;
            par_val   <= par_val_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - randomized and directed checks of uart_tx_framer against a frame-level model
module tb_uart_tx_framer;
    localparam int CLKS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       send;
    logic [7:0] data_in;
    logic [1:0] parity_type;
    logic       parity_bit;

    int tests = 0;
    int fails = 0;

    uart_tx_framer_if ifa ();
    uart_tx_framer_if ifb ();

    assign ifa.send = send;  assign ifa.data_in = data_in;
    assign ifa.parity_type = parity_type;  assign ifa.parity_bit = parity_bit;
    assign ifb.send = send;  assign ifb.data_in = data_in;
    assign ifb.parity_type = parity_type;  assign ifb.parity_bit = parity_bit;

    uart_tx_framer #(.CLKS_PER_BIT(CLKS), .STOP_BITS(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    uart_tx_framer #(.CLKS_PER_BIT(CLKS), .STOP_BITS(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic parity_of(input logic [7:0] d, input logic [1:0] pt);
        if (pt == 2'b01) return ~^d;
        if (pt == 2'b10) return ^d;
        return 1'($urandom_range(0, 1));
    endfunction

    // Frame-level model: a frame is a list of bit levels, each held for CLKS cycles.
    int          stop_n [2] = '{1, 2};
    bit          active [2] = '{0, 0};
    int          cyc    [2] = '{0, 0};
    int          nbits  [2] = '{0, 0};
    logic [11:0] frame  [2];
    bit          exp_done [2] = '{0, 0};
    int          exp_len  [2] = '{0, 0};
    int          busy_cnt [2] = '{0, 0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_done[d] = 0;
            if (!reset) begin
                active[d] = 0;
            end else if (active[d]) begin
                cyc[d]++;
                if (cyc[d] == nbits[d] * CLKS) begin
                    active[d]   = 0;
                    exp_done[d] = 1;
                end
            end else if (send) begin
                int p;
                p = (parity_type == 2'b01 || parity_type == 2'b10) ? 1 : 0;
                frame[d]      = 12'hFFF;
                frame[d][0]   = 1'b0;
                frame[d][8:1] = data_in;
                if (p == 1) frame[d][9] = parity_bit;
                nbits[d]   = 9 + p + stop_n[d];
                exp_len[d] = (1 + 8 + p + stop_n[d]) * CLKS;
                cyc[d]     = 0;
                active[d]  = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] obs [2];
        obs[0] = {ifa.tx, ifa.busy, ifa.done};
        obs[1] = {ifb.tx, ifb.busy, ifb.done};
        for (int d = 0; d < 2; d++) begin
            logic etx;
            etx = active[d] ? frame[d][cyc[d] / CLKS] : 1'b1;
            check(d == 0 ? "tx_a" : "tx_b", 32'(obs[d][2]), 32'(etx));
            check(d == 0 ? "busy_a" : "busy_b", 32'(obs[d][1]), 32'(active[d]));
            check(d == 0 ? "done_a" : "done_b", 32'(obs[d][0]), 32'(exp_done[d]));
            if (obs[d][1]) busy_cnt[d]++;
            if (obs[d][0]) begin
                check(d == 0 ? "busy_len_a" : "busy_len_b", 32'(busy_cnt[d]), 32'(exp_len[d]));
                busy_cnt[d] = 0;
            end else if (!obs[d][1]) begin
                busy_cnt[d] = 0;
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt);
        data_in     = d;
        parity_type = pt;
        parity_bit  = parity_of(d, pt);
        send        = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (!ifa.busy && !ifb.busy) ok = 1;
            else @(negedge clk);
        end
        if (!ok) check("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic parity_frame(input logic [7:0] d, input logic [1:0] pt, input logic exp_par);
        send_frame(d, pt);
        repeat (37) @(negedge clk);
        check("parity_a", 32'(ifa.tx), 32'(exp_par));
        check("parity_b", 32'(ifb.tx), 32'(exp_par));
        wait_idle();
    endtask

    initial begin
        reset = 1'b0; send = 1'b1; data_in = 8'hA5; parity_type = 2'b01;
        parity_bit = parity_of(8'hA5, 2'b01);
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", 32'(ifa.tx), 1);
            check("rst_busy", 32'(ifa.busy), 0);
            check("rst_done", 32'(ifb.done), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("rst_release_start", 32'(ifa.busy), 1);
        wait_idle();

        parity_frame(8'b0000_0001, 2'b01, 1'b0);
        parity_frame(8'b0000_0011, 2'b10, 1'b0);
        parity_frame(8'b0000_0001, 2'b10, 1'b1);
        send_frame(8'hFF, 2'b00);
        wait_idle();

        // A send pulse mid-frame must be ignored.
        send_frame(8'h96, 2'b01);
        repeat (15) @(negedge clk);
        send_frame(8'h00, 2'b10);
        wait_idle();

        send_frame(8'h5A, 2'b00);
        for (int i = 0; i < 100 && !ifa.done; i++) @(negedge clk);
        check("b2b_done_seen", 32'(ifa.done), 1);
        send_frame(8'h3C, 2'b00);
        check("b2b_start_tx", 32'(ifa.tx), 0);
        check("b2b_start_busy", 32'(ifa.busy), 1);
        wait_idle();

        // Abort during data bit 4.
        send_frame(8'hC3, 2'b10);
        repeat (20) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_tx", 32'(ifa.tx), 1);
        check("abort_busy", 32'(ifb.busy), 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_done", 32'(ifa.done | ifb.done), 0);
        send_frame(8'h81, 2'b01);
        wait_idle();

        for (int i = 0; i < 4000; i++) begin
            send        = ($urandom_range(0, 3) == 0);
            data_in     = 8'($urandom);
            parity_type = 2'($urandom);
            parity_bit  = parity_of(data_in, parity_type);
            reset       = ($urandom_range(0, 599) != 0);
            @(negedge clk);
        end
        reset = 1'b1;
        send  = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
